exec_unit: RTL and testbench

Multi-cycle execute/write-back stage for the 8-register datapath. Accepts one decoded instruction, reads two source operands from the register file through its two read ports, computes an ALU result with flags, and writes the result back through the register file write port. Sits directly around `RegisterFile`: it drives `RegisterFile`'s read addresses, consumes its read data, and drives its write port.

---
 rtl/exec_pkg.sv | 27 ++
 rtl/exec_alu.sv | 63 ++++++
 rtl/exec_unit.sv | 143 ++++++++++++++
 tb/tb_exec_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute/write-back stage.
// Provides the opcode encoding, the FSM state encoding and the opcode width.
package exec_pkg;

    localparam int unsigned OPCODE_WIDTH = 3;

    // ALU operation select.
    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_LDI = 3'b111
    } opcode_e;

    // Execute-stage sequencing.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EXEC = 2'b10,
        ST_WB   = 2'b11
    } state_e;

endpackage : exec_pkg

// File: rtl/exec_alu.sv
// Combinational ALU for the execute stage.
// Ports:
//   a, b      - source operands (rs, rt values)
//   imm       - immediate used by LDI
//   opcode    - operation select
//   result_c  - operation result, modulo 2^DATA_WIDTH
//   zero_c    - result equals zero
//   carry_c   - carry-out / borrow / shifted-out bit, 0 for logic ops and LDI
module exec_alu
    import exec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] imm,
    input  opcode_e               opcode,
    output logic [DATA_WIDTH-1:0] result_c,
    output logic                  zero_c,
    output logic                  carry_c
);

    // One extra bit catches carry-out on ADD and borrow on SUB.
    logic [DATA_WIDTH:0] wide_c;

    // Operation decode.
    always_comb begin
        result_c = '0;
        carry_c  = 1'b0;
        wide_c   = '0;
        case (opcode)
            OP_ADD: begin
                wide_c   = {1'b0, a} + {1'b0, b};
                result_c = wide_c[DATA_WIDTH-1:0];
                carry_c  = wide_c[DATA_WIDTH];
            end
            OP_SUB: begin
                wide_c   = {1'b0, a} - {1'b0, b};
                result_c = wide_c[DATA_WIDTH-1:0];
                carry_c  = wide_c[DATA_WIDTH];
            end
            OP_AND: result_c = a & b;
            OP_OR:  result_c = a | b;
            OP_XOR: result_c = a ^ b;
            OP_SHL: begin
                result_c = {a[DATA_WIDTH-2:0], 1'b0};
                carry_c  = a[DATA_WIDTH-1];
            end
            OP_SHR: begin
                result_c = {1'b0, a[DATA_WIDTH-1:1]};
                carry_c  = a[0];
            end
            OP_LDI: result_c = imm;
            default: begin
                result_c = '0;
                carry_c  = 1'b0;
            end
        endcase
    end

    assign zero_c = (result_c == '0);

endmodule : exec_alu

// File: rtl/exec_unit.sv
// Multi-cycle execute/write-back stage wrapped around an external register file.
// Sequence per instruction: IDLE -> READ -> EXEC -> WB -> IDLE.
// Ports:
//   clk, reset               - clock, asynchronous active-high reset
//   start                    - instruction valid, honoured only in IDLE
//   opcode, rd, rs, rt, imm  - decoded instruction fields
//   busy                     - high in every state except IDLE
//   done                     - one-cycle pulse in the write-back cycle
//   zero, carry              - flags of the last completed operation
//   rf_r_addr, rf_r2_addr    - register file read addresses (latched rs, rt)
//   rf_r_data, rf_r2_data    - register file combinational read data
//   rf_wr_en                 - register file write enable (WB only)
//   rf_w_addr, rf_w_data     - write address (latched rd) and result
module exec_unit
    import exec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [ADDR_WIDTH-1:0]   rd,
    input  logic [ADDR_WIDTH-1:0]   rs,
    input  logic [ADDR_WIDTH-1:0]   rt,
    input  logic [DATA_WIDTH-1:0]   imm,
    output logic                    busy,
    output logic                    done,
    output logic                    zero,
    output logic                    carry,
    output logic [ADDR_WIDTH-1:0]   rf_r_addr,
    output logic [ADDR_WIDTH-1:0]   rf_r2_addr,
    input  logic [DATA_WIDTH-1:0]   rf_r_data,
    input  logic [DATA_WIDTH-1:0]   rf_r2_data,
    output logic                    rf_wr_en,
    output logic [ADDR_WIDTH-1:0]   rf_w_addr,
    output logic [DATA_WIDTH-1:0]   rf_w_data
);

    state_e                  state_q;
    state_e                  state_d;
    logic                    accept_c;
    logic                    capture_c;
    logic                    commit_c;

    opcode_e                 op_q;
    logic [DATA_WIDTH-1:0]   imm_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;

    logic [DATA_WIDTH-1:0]   alu_result_c;
    logic                    alu_zero_c;
    logic                    alu_carry_c;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state strobes.
    always_comb begin
        state_d   = state_q;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        commit_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_READ;
                    accept_c = 1'b1;
                end
            end
            ST_READ: begin
                state_d   = ST_EXEC;
                capture_c = 1'b1;
            end
            ST_EXEC: begin
                state_d  = ST_WB;
                commit_c = 1'b1;
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status decodes straight from the state register, no added latency.
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_WB);
    assign rf_wr_en = (state_q == ST_WB);

    // Instruction latches, operand capture, result and flag registers.
    // Read addresses are the latched rs/rt, so they are already valid in READ
    // and hold their value afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= OP_ADD;
            imm_q      <= '0;
            rf_r_addr  <= '0;
            rf_r2_addr <= '0;
            rf_w_addr  <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rf_w_data  <= '0;
            zero       <= 1'b0;
            carry      <= 1'b0;
        end else begin
            if (accept_c) begin
                op_q       <= opcode_e'(opcode);
                imm_q      <= imm;
                rf_r_addr  <= rs;
                rf_r2_addr <= rt;
                rf_w_addr  <= rd;
            end
            if (capture_c) begin
                a_q <= rf_r_data;
                b_q <= rf_r2_data;
            end
            if (commit_c) begin
                rf_w_data <= alu_result_c;
                zero      <= alu_zero_c;
                carry     <= alu_carry_c;
            end
        end
    end

    exec_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .a        (a_q),
        .b        (b_q),
        .imm      (imm_q),
        .opcode   (op_q),
        .result_c (alu_result_c),
        .zero_c   (alu_zero_c),
        .carry_c  (alu_carry_c)
    );

endmodule : exec_unit

// File: tb/tb_exec_unit.sv
// Testbench for exec_unit with an 8x8 register file and an instruction-level model.
module tb_exec_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic [2:0] rd = 3'd0;
    logic [2:0] rs = 3'd0;
    logic [2:0] rt = 3'd0;
    logic [7:0] imm = 8'd0;
    logic       busy, done, zero, carry, rf_wr_en;
    logic [2:0] rf_r_addr, rf_r2_addr, rf_w_addr;
    logic [7:0] rf_r_data, rf_r2_data, rf_w_data;

    int n_pass = 0;
    int n_total = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    // Register file: combinational read, synchronous write.
    logic [7:0] rf [8] = '{default: 8'h00};
    assign rf_r_data  = rf[rf_r_addr];
    assign rf_r2_data = rf[rf_r2_addr];
    always @(posedge clk) if (rf_wr_en) rf[rf_w_addr] <= rf_w_data;

    exec_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .opcode     (opcode),
        .rd         (rd),
        .rs         (rs),
        .rt         (rt),
        .imm        (imm),
        .busy       (busy),
        .done       (done),
        .zero       (zero),
        .carry      (carry),
        .rf_r_addr  (rf_r_addr),
        .rf_r2_addr (rf_r2_addr),
        .rf_r_data  (rf_r_data),
        .rf_r2_data (rf_r2_data),
        .rf_wr_en   (rf_wr_en),
        .rf_w_addr  (rf_w_addr),
        .rf_w_data  (rf_w_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Instruction-level model: cycles remaining until the instruction retires,
    // its expected outcome, the architecturally visible flags and register contents.
    int         m_left = 0;
    int         e_rd, e_rs, e_rt, e_res;
    bit         e_zero, e_carry;
    bit         m_zero = 0, m_carry = 0;
    int         ref_rf [8] = '{default: 0};

    always @(posedge clk) begin
        if (reset) begin
            m_left  = 0;
            m_zero  = 0;
            m_carry = 0;
        end else if (m_left != 0) begin
            if (m_left == 2) begin
                m_zero  = e_zero;
                m_carry = e_carry;
            end
            if (m_left == 1) ref_rf[e_rd] = e_res;
            m_left--;
        end else if (start) begin
            int a, b, s;
            a = ref_rf[rs];
            b = ref_rf[rt];
            e_carry = 0;
            case (opcode)
                3'd0: begin s = a + b; e_res = s % 256; e_carry = (s > 255); end
                3'd1: begin e_res = (a - b + 256) % 256; e_carry = (a < b); end
                3'd2: e_res = a & b;
                3'd3: e_res = a | b;
                3'd4: e_res = a ^ b;
                3'd5: begin e_res = (a * 2) % 256; e_carry = (a >= 128); end
                3'd6: begin e_res = a / 2; e_carry = (a % 2 == 1); end
                default: e_res = int'(imm);
            endcase
            e_zero = (e_res == 0);
            e_rd = int'(rd);
            e_rs = int'(rs);
            e_rt = int'(rt);
            m_left = 3;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (done) done_cnt++;
        check("busy", 32'(busy), 32'(m_left != 0));
        check("done", 32'(done), 32'(m_left == 1));
        check("rf_wr_en", 32'(rf_wr_en), 32'(m_left == 1));
        check("zero", 32'(zero), 32'(m_zero));
        check("carry", 32'(carry), 32'(m_carry));
        if (m_left == 3) begin
            check("rf_r_addr", 32'(rf_r_addr), 32'(e_rs));
            check("rf_r2_addr", 32'(rf_r2_addr), 32'(e_rt));
        end
        if (m_left == 1) begin
            check("rf_w_addr", 32'(rf_w_addr), 32'(e_rd));
            check("rf_w_data", 32'(rf_w_data), 32'(e_res));
        end
    end

    // Issue one instruction; returns at the negedge of its WB cycle.
    task automatic run_op(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s,
                          input logic [2:0] t, input logic [7:0] im);
        @(negedge clk);
        start = 1'b1; opcode = op; rd = d; rs = s; rt = t; imm = im;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Issue, then pin flags in WB and the written register after the write edge.
    task automatic run_check(input string name, input logic [2:0] op, input logic [2:0] d,
                             input logic [2:0] s, input logic [2:0] t, input logic [7:0] im,
                             input logic [7:0] exp_val, input logic exp_z, input logic exp_c);
        run_op(op, d, s, t, im);
        check({name, " zero"}, 32'(zero), 32'(exp_z));
        check({name, " carry"}, 32'(carry), 32'(exp_c));
        @(posedge clk); #1;
        check({name, " reg"}, 32'(rf[d]), 32'(exp_val));
    endtask

    initial begin
        int dc0;
        // Reset with a start request that must be ignored.
        reset = 1'b1;
        start = 1'b1; opcode = 3'd7; rd = 3'd7; rs = 3'd5; rt = 3'd6; imm = 8'h99;
        repeat (2) begin
            @(negedge clk);
            check("rst busy", 32'(busy), 32'd0);
            check("rst done", 32'(done), 32'd0);
            check("rst wr_en", 32'(rf_wr_en), 32'd0);
            check("rst flags", {30'd0, zero, carry}, 32'd0);
            check("rst addrs", {23'd0, rf_r_addr, rf_r2_addr, rf_w_addr}, 32'd0);
            check("rst w_data", 32'(rf_w_data), 32'd0);
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("post-rst busy", 32'(busy), 32'd0);
        check("post-rst r7", 32'(rf[7]), 32'h00);

        run_check("ldi r1", 3'd7, 3'd1, 3'd0, 3'd0, 8'h45, 8'h45, 1'b0, 1'b0);
        run_check("ldi r2", 3'd7, 3'd2, 3'd0, 3'd0, 8'h03, 8'h03, 1'b0, 1'b0);
        run_check("add r3", 3'd0, 3'd3, 3'd1, 3'd2, 8'h00, 8'h48, 1'b0, 1'b0);
        run_check("ldi r4", 3'd7, 3'd4, 3'd0, 3'd0, 8'hF0, 8'hF0, 1'b0, 1'b0);
        run_check("ldi r5", 3'd7, 3'd5, 3'd0, 3'd0, 8'h10, 8'h10, 1'b0, 1'b0);
        run_check("add wrap", 3'd0, 3'd6, 3'd4, 3'd5, 8'h00, 8'h00, 1'b1, 1'b1);
        run_check("sub borrow", 3'd1, 3'd6, 3'd2, 3'd1, 8'h00, 8'hBE, 1'b0, 1'b1);
        run_check("ldi r7", 3'd7, 3'd7, 3'd0, 3'd0, 8'h81, 8'h81, 1'b0, 1'b0);
        run_check("shl", 3'd5, 3'd7, 3'd7, 3'd0, 8'h00, 8'h02, 1'b0, 1'b1);
        run_check("ldi r4b", 3'd7, 3'd4, 3'd0, 3'd0, 8'h01, 8'h01, 1'b0, 1'b0);
        run_check("shr", 3'd6, 3'd4, 3'd4, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1);
        run_check("ldi r4c", 3'd7, 3'd4, 3'd0, 3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        run_check("ldi r5b", 3'd7, 3'd5, 3'd0, 3'd0, 8'h0F, 8'h0F, 1'b0, 1'b0);
        run_check("xor", 3'd4, 3'd4, 3'd4, 3'd5, 8'h00, 8'hF0, 1'b0, 1'b0);

        // ADD r1=r1+r1 with a second start (OR into r5) held through READ/EXEC/WB.
        dc0 = done_cnt;
        @(negedge clk);
        start = 1'b1; opcode = 3'd0; rd = 3'd1; rs = 3'd1; rt = 3'd1;
        @(negedge clk);
        opcode = 3'd3; rd = 3'd5; rs = 3'd2; rt = 3'd3;
        repeat (2) @(negedge clk);
        check("self add zero", 32'(zero), 32'd0);
        check("self add carry", 32'(carry), 32'd0);
        @(posedge clk); #1;
        check("self add r1", 32'(rf[1]), 32'h8A);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("ignored start r5", 32'(rf[5]), 32'h0F);
        check("single done", 32'(done_cnt - dc0), 32'd1);

        run_check("ldi r4d", 3'd7, 3'd4, 3'd0, 3'd0, 8'h11, 8'h11, 1'b0, 1'b0);
        run_check("sub r0", 3'd1, 3'd0, 3'd2, 3'd1, 8'h00, 8'h79, 1'b0, 1'b1);

        // Reset pulse during EXEC of ADD r4 suppresses the write and clears flags.
        @(negedge clk);
        start = 1'b1; opcode = 3'd0; rd = 3'd4; rs = 3'd1; rt = 3'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("abort wr_en", 32'(rf_wr_en), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort flags", {30'd0, zero, carry}, 32'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        check("abort r4", 32'(rf[4]), 32'h11);
        @(negedge clk);
        check("abort r4 later", 32'(rf[4]), 32'h11);
        run_check("ldi r4e", 3'd7, 3'd4, 3'd0, 3'd0, 8'h22, 8'h22, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_exec_unit
